// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared data-memory port: split command/response
// handshake, one outstanding read, grant locked until the command is accepted.
module dmem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             r0_valid_i,
  output logic             r0_ready_o,
  input  logic             r0_wen_i,
  input  logic [XLEN-1:0]  r0_addr_i,
  input  logic [XLEN-1:0]  r0_wdata_i,
  input  logic [1:0]       r0_wmask_i,
  output logic             r0_rvalid_o,
  output logic [XLEN-1:0]  r0_rdata_o,
  // requester 1
  input  logic             r1_valid_i,
  output logic             r1_ready_o,
  input  logic             r1_wen_i,
  input  logic [XLEN-1:0]  r1_addr_i,
  input  logic [XLEN-1:0]  r1_wdata_i,
  input  logic [1:0]       r1_wmask_i,
  output logic             r1_rvalid_o,
  output logic [XLEN-1:0]  r1_rdata_o,
  // memory port
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_wen_o,
  output logic [XLEN-1:0]  m_addr_o,
  output logic [XLEN-1:0]  m_wdata_o,
  output logic [1:0]       m_wmask_o,
  input  logic             m_rvalid_i,
  input  logic [XLEN-1:0]  m_rdata_i,
  // accepted-command counters
  output logic [CNT_W-1:0] gnt_cnt0_o,
  output logic [CNT_W-1:0] gnt_cnt1_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic             last_gnt_q, last_gnt_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             gnt_id;
  logic             gnt_vld;
  logic             gnt_wen;

  // Grant selection: a locked grant overrides priority until it is accepted.
  always_comb begin
    gnt_id = 1'b0;
    if (lock_q) begin
      gnt_id = lock_id_q;
    end else if (r0_valid_i && r1_valid_i) begin
      gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
    end else begin
      gnt_id = r1_valid_i;
    end
    gnt_vld = gnt_id ? r1_valid_i : r0_valid_i;
    gnt_wen = gnt_id ? r1_wen_i   : r0_wen_i;
  end

  // Next-state, forwarding and response steering.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    m_valid_o   = 1'b0;
    m_wen_o     = 1'b0;
    m_addr_o    = '0;
    m_wdata_o   = '0;
    m_wmask_o   = 2'b00;
    r0_ready_o  = 1'b0;
    r1_ready_o  = 1'b0;
    r0_rvalid_o = 1'b0;
    r1_rvalid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          m_valid_o  = 1'b1;
          m_wen_o    = gnt_wen;
          m_addr_o   = gnt_id ? r1_addr_i  : r0_addr_i;
          m_wdata_o  = gnt_id ? r1_wdata_i : r0_wdata_i;
          m_wmask_o  = gnt_id ? r1_wmask_i : r0_wmask_i;
          r0_ready_o = ~gnt_id & m_ready_i;
          r1_ready_o =  gnt_id & m_ready_i;
          if (!m_ready_i) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
          end else begin
            lock_d     = 1'b0;
            last_gnt_d = gnt_id;
            if (gnt_id) cnt1_d = cnt1_q + CNT_W'(1);
            else        cnt0_d = cnt0_q + CNT_W'(1);
            if (!gnt_wen) begin
              owner_d = gnt_id;
              state_d = WAIT_RESP;
            end
          end
        end else begin
          // grantee withdrew its request: drop any stale lock
          lock_d = 1'b0;
        end
      end
      WAIT_RESP: begin
        if (m_rvalid_i) begin
          r0_rvalid_o = ~owner_q;
          r1_rvalid_o =  owner_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign r0_rdata_o = m_rdata_i;
  assign r1_rdata_o = m_rdata_i;
  assign gnt_cnt0_o = cnt0_q;
  assign gnt_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: instance 0 round-robin, instance 1
// fixed-priority, each with its own requester and memory-side stimulus.
module tb_dmem_port_arbiter;

  typedef struct {
    int          k;
    int          id;
    logic        wen;
    logic [31:0] addr;
  } gnt_t;

  typedef struct {
    int          k;
    int          id;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        rv     [2][2];
  logic        rw     [2][2];
  logic [31:0] ra     [2][2];
  logic [31:0] rd     [2][2];
  logic [1:0]  rm     [2][2];
  logic        rr     [2][2];
  logic        rrv    [2][2];
  logic [31:0] rrd    [2][2];
  logic        mv     [2];
  logic        mr     [2];
  logic        mwen   [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic [1:0]  mwmask [2];
  logic        mrv    [2];
  logic [31:0] mrd    [2];
  logic [31:0] cnt0   [2];
  logic [31:0] cnt1   [2];

  bit          auto_mem [2];
  logic        acc_ld   [2];
  logic        acc_id   [2];
  int          resp_seq;
  int          n_checks;
  int          n_errors;
  gnt_t        gq[$];
  resp_t       rq[$];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dmem_port_arbiter #(.XLEN(32), .FIXED_PRIO(k), .CNT_W(32)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .r0_valid_i (rv[k][0]),
      .r0_ready_o (rr[k][0]),
      .r0_wen_i   (rw[k][0]),
      .r0_addr_i  (ra[k][0]),
      .r0_wdata_i (rd[k][0]),
      .r0_wmask_i (rm[k][0]),
      .r0_rvalid_o(rrv[k][0]),
      .r0_rdata_o (rrd[k][0]),
      .r1_valid_i (rv[k][1]),
      .r1_ready_o (rr[k][1]),
      .r1_wen_i   (rw[k][1]),
      .r1_addr_i  (ra[k][1]),
      .r1_wdata_i (rd[k][1]),
      .r1_wmask_i (rm[k][1]),
      .r1_rvalid_o(rrv[k][1]),
      .r1_rdata_o (rrd[k][1]),
      .m_valid_o  (mv[k]),
      .m_ready_i  (mr[k]),
      .m_wen_o    (mwen[k]),
      .m_addr_o   (maddr[k]),
      .m_wdata_o  (mwdata[k]),
      .m_wmask_o  (mwmask[k]),
      .m_rvalid_i (mrv[k]),
      .m_rdata_i  (mrd[k]),
      .gnt_cnt0_o (cnt0[k]),
      .gnt_cnt1_o (cnt1[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input int r, input logic v, input logic w,
                         input logic [31:0] a);
    rv[k][r] = v;
    rw[k][r] = w;
    ra[k][r] = a;
    rd[k][r] = a ^ 32'hA5A5_0000;
    rm[k][r] = 2'd2;
  endtask

  task automatic push_gnt(input int k, input int id, input logic w, input logic [31:0] a);
    gnt_t e;
    e.k = k; e.id = id; e.wen = w; e.addr = a;
    gq.push_back(e);
  endtask

  task automatic push_resp(input int k, input int id, input logic [31:0] d);
    resp_t e;
    e.k = k; e.id = id; e.data = d;
    rq.push_back(e);
  endtask

  // One clock; the optional memory model answers each accepted load next cycle.
  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      acc_ld[k] = mv[k] & mr[k] & ~mwen[k];
      acc_id[k] = maddr[k][9];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (auto_mem[k]) begin
        mrv[k] = acc_ld[k];
        if (acc_ld[k]) begin
          mrd[k] = 32'hC0DE_0000 | 32'(resp_seq);
          resp_seq++;
          push_resp(k, int'(acc_id[k]), mrd[k]);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) set_req(k, r, 1'b0, 1'b0, 32'h0);
      mr[k] = 1'b0; mrv[k] = 1'b0; mrd[k] = 32'h0; auto_mem[k] = 1'b0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: accepted commands and read responses against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk("rdy_no_vld", 64'((rr[k][0] | rr[k][1]) & ~mv[k]), 64'd0);
        if (mv[k] && mr[k]) begin
          if (gq.size() == 0) chk("gnt_unexpected", 64'(gq.size()), 64'd1);
          else begin
            gnt_t e;
            e = gq.pop_front();
            chk("gnt_inst", 64'(k), 64'(e.k));
            chk("gnt_ready", 64'({rr[k][1], rr[k][0]}), (e.id == 1) ? 64'd2 : 64'd1);
            chk("gnt_addr", 64'(maddr[k]), 64'(e.addr));
            chk("gnt_wen", 64'(mwen[k]), 64'(e.wen));
            chk("gnt_wdata", 64'(mwdata[k]), 64'(e.addr ^ 32'hA5A5_0000));
            chk("gnt_wmask", 64'(mwmask[k]), 64'd2);
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (rrv[k][r]) begin
            if (rq.size() == 0) chk("resp_unexpected", 64'(rq.size()), 64'd1);
            else begin
              resp_t e;
              e = rq.pop_front();
              chk("resp_inst", 64'(k), 64'(e.k));
              chk("resp_id", 64'(r), 64'(e.id));
              chk("resp_data", 64'(rrd[k][r]), 64'(e.data));
            end
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    resp_seq = 0;
    do_reset();
    @(negedge clk);
    chk("rst_mvalid", 64'(mv[0] | mv[1]), 64'd0);
    chk("rst_cnt", 64'({cnt0[0], cnt1[0]}), 64'd0);
    chk("rst_rvalid", 64'({rrv[0][0], rrv[0][1], rrv[1][0], rrv[1][1]}), 64'd0);
    @(posedge clk);
    #1;

    // single load from r0, response two cycles after accept
    set_req(0, 0, 1'b1, 1'b0, 32'h100); mr[0] = 1'b1;
    push_gnt(0, 0, 1'b0, 32'h100);
    cyc();
    rv[0][0] = 1'b0; mr[0] = 1'b0;
    cyc();
    mrv[0] = 1'b1; mrd[0] = 32'hDEAD_BEEF;
    push_resp(0, 0, 32'hDEAD_BEEF);
    cyc();
    mrv[0] = 1'b0;
    cyc();
    chk("t1_cnt0", 64'(cnt0[0]), 64'd1);
    chk("t1_cnt1", 64'(cnt1[0]), 64'd0);

    // round-robin with both requesters loading continuously
    do_reset();
    auto_mem[0] = 1'b1; mr[0] = 1'b1;
    set_req(0, 0, 1'b1, 1'b0, 32'h110);
    set_req(0, 1, 1'b1, 1'b0, 32'h210);
    for (int i = 0; i < 8; i++) push_gnt(0, i % 2, 1'b0, (i % 2 == 0) ? 32'h110 : 32'h210);
    repeat (16) cyc();
    rv[0][0] = 1'b0; rv[0][1] = 1'b0;
    cyc();
    auto_mem[0] = 1'b0; mr[0] = 1'b0;
    cyc();
    chk("t2_cnt0", 64'(cnt0[0]), 64'd4);
    chk("t2_cnt1", 64'(cnt1[0]), 64'd4);

    // spurious m_rvalid in IDLE
    mrv[0] = 1'b1; mrd[0] = 32'h0000_1234;
    #3;
    chk("t5_rvalid", 64'({rrv[0][0], rrv[0][1]}), 64'd0);
    chk("t5_rdata0", 64'(rrd[0][0]), 64'h1234);
    chk("t5_rdata1", 64'(rrd[0][1]), 64'h1234);
    cyc();
    mrv[0] = 1'b0;
    #3;
    chk("t5_cnt0", 64'(cnt0[0]), 64'd4);
    chk("t5_cnt1", 64'(cnt1[0]), 64'd4);
    set_req(0, 0, 1'b1, 1'b1, 32'h104); mr[0] = 1'b1;
    push_gnt(0, 0, 1'b1, 32'h104);
    cyc();
    rv[0][0] = 1'b0; mr[0] = 1'b0;
    cyc();
    chk("t5_cnt0_after", 64'(cnt0[0]), 64'd5);

    // fixed priority: r0 store stream starves r1 load
    do_reset();
    auto_mem[1] = 1'b1; mr[1] = 1'b1;
    set_req(1, 1, 1'b1, 1'b0, 32'h280);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 0, 1'b1, 1'b1, 32'h180 + 32'(4 * i));
      push_gnt(1, 0, 1'b1, 32'h180 + 32'(4 * i));
      cyc();
    end
    rv[1][0] = 1'b0;
    push_gnt(1, 1, 1'b0, 32'h280);
    cyc();
    rv[1][1] = 1'b0;
    cyc();
    auto_mem[1] = 1'b0; mr[1] = 1'b0;
    cyc();
    chk("t3_cnt0", 64'(cnt0[1]), 64'd4);
    chk("t3_cnt1", 64'(cnt1[1]), 64'd1);

    // lock holds r1 while memory stalls, even against higher-priority r0
    do_reset();
    set_req(1, 1, 1'b1, 1'b1, 32'h204);
    #3 chk("t4_addr_c0", 64'(maddr[1]), 64'h204);
    cyc();
    set_req(1, 0, 1'b1, 1'b1, 32'h104);
    #3 chk("t4_addr_c1", 64'(maddr[1]), 64'h204);
    cyc();
    #3 chk("t4_addr_c2", 64'(maddr[1]), 64'h204);
    cyc();
    mr[1] = 1'b1;
    push_gnt(1, 1, 1'b1, 32'h204);
    cyc();
    rv[1][1] = 1'b0;
    push_gnt(1, 0, 1'b1, 32'h104);
    cyc();
    rv[1][0] = 1'b0; mr[1] = 1'b0;
    cyc();
    chk("t4_cnt0", 64'(cnt0[1]), 64'd1);
    chk("t4_cnt1", 64'(cnt1[1]), 64'd1);

    // reset while a read is outstanding; late response must be dropped
    set_req(0, 0, 1'b1, 1'b0, 32'h100); mr[0] = 1'b1;
    push_gnt(0, 0, 1'b0, 32'h100);
    cyc();
    rv[0][0] = 1'b0; mr[0] = 1'b0;
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_cnt0_rst", 64'(cnt0[0]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mrv[0] = 1'b1; mrd[0] = 32'hBEEF_0001;
    #3 chk("t6_late_rvalid", 64'({rrv[0][0], rrv[0][1]}), 64'd0);
    cyc();
    mrv[0] = 1'b0;
    set_req(0, 1, 1'b1, 1'b0, 32'h200); mr[0] = 1'b1;
    push_gnt(0, 1, 1'b0, 32'h200);
    cyc();
    rv[0][1] = 1'b0; mr[0] = 1'b0;
    mrv[0] = 1'b1; mrd[0] = 32'h0000_2222;
    push_resp(0, 1, 32'h0000_2222);
    cyc();
    mrv[0] = 1'b0;
    cyc();
    chk("t6_cnt0", 64'(cnt0[0]), 64'd0);
    chk("t6_cnt1", 64'(cnt1[0]), 64'd1);

    chk("gnt_q_left", 64'(gq.size()), 64'd0);
    chk("resp_q_left", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 (memory stage loads/stores/AMOs) and requester 1 (instruction fetch or a future page-table walker).
- Sits between the requesters and the memory unit. Uses the same split handshake as the memory port: command valid/ready, then a separate read-response valid.
- Allows at most one outstanding read. Arbitrates round-robin or fixed-priority, locks a grant until the command is accepted, and routes read data back to the owner.

Parameters:
- XLEN, 32, data and address width
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins when both request
- CNT_W, 32, width of the per-requester grant counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 command valid
- r0_ready  out  1  requester 0 command accepted
- r0_wen  in  1  1 = store, 0 = load
- r0_addr  in  XLEN  address
- r0_wdata  in  XLEN  store data
- r0_wmask  in  2  access size code (B/H/W), passed through
- r0_rvalid  out  1  read response valid
- r0_rdata  out  XLEN  read response data
- r1_*: same eight signals as r0_*, for requester 1
- m_valid  out  1  memory command valid
- m_ready  in  1  memory command accepted
- m_wen  out  1  selected wen
- m_addr  out  XLEN  selected address
- m_wdata  out  XLEN  selected wdata
- m_wmask  out  2  selected wmask
- m_rvalid  in  1  memory read response valid
- m_rdata  in  XLEN  memory read data
- gnt_cnt0  out  CNT_W  accepted commands for requester 0
- gnt_cnt1  out  CNT_W  accepted commands for requester 1

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, lock = 0, last_gnt = 1 (so requester 0 wins the first round-robin tie), owner = 0, both counters = 0.
  - All outputs deasserted or zero.
- States: IDLE, WAIT_RESP.
- IDLE, grant selection:
  - If lock = 1, grant = locked requester.
  - Otherwise, if exactly one requester is valid, it is granted.
  - If both are valid: with FIXED_PRIO = 1, requester 0 wins; with FIXED_PRIO = 0, the requester other than last_gnt wins.
  - If no requester is valid, there is no grant and m_valid = 0.
- IDLE, forwarding (combinational, zero latency):
  - m_valid = grantee valid; m_wen/addr/wdata/wmask = grantee fields.
  - Grantee ready = m_ready; the non-grantee ready = 0.
- IDLE, lock:
  - If m_valid = 1 and m_ready = 0, set lock and record the grantee. The grant stays fixed until acceptance, even if the other requester has priority.
- IDLE, acceptance (m_valid && m_ready):
  - Clear lock, set last_gnt = grantee, increment the grantee's counter (wraps at 2^CNT_W).
  - Store (wen = 1): remain in IDLE; a new grant is possible on the next cycle.
  - Load (wen = 0): latch owner = grantee and move to WAIT_RESP.
- WAIT_RESP:
  - m_valid = 0; r0_ready = r1_ready = 0.
  - On m_rvalid, pulse owner's rvalid for that same cycle with rdata = m_rdata, then return to IDLE.
  - Arbitration resumes the following cycle, so there is no back-to-back accept in the response cycle.
- Response routing:
  - r0_rdata and r1_rdata always carry m_rdata; only rvalid is steered to the owner.
  - m_rvalid in IDLE is spurious: it is ignored and neither rvalid asserts.
- Requester obligations:
  - Hold valid and all fields stable until ready.
  - Dropping valid while locked is a protocol error; the arbiter then releases the lock when the grantee's valid is 0 and m_valid falls.
- AMO sequences (load then store) from requester 0 are two separate commands. The arbiter guarantees no atomicity between them.
- Reset mid-operation: any outstanding read is abandoned. A late m_rvalid after reset arrives in IDLE and is ignored.

Test Plan:
- Single load from r0, addr 0x100, with m_ready high and m_rvalid two cycles later carrying 0xDEADBEEF -> r0_ready for 1 cycle; r0_rvalid 1 cycle with 0xDEADBEEF; r1_rvalid stays 0; gnt_cnt0 = 1.
- Both requesters hold valid loads every cycle, FIXED_PRIO = 0, memory answers each load with latency 1 -> grants alternate 0,1,0,1; after 8 accepts gnt_cnt0 = gnt_cnt1 = 4.
- FIXED_PRIO = 1, r0 issues stores (m_ready high every cycle) while r1 holds a load -> r1 is never granted while r0 is valid; r1 is granted the cycle after r0 drops valid.
- r1 granted with m_ready low for 3 cycles, and r0 raises valid in cycle 1 (FIXED_PRIO = 1) -> m_addr stays on r1 for all 3 cycles; r1 is accepted in cycle 3 and r0 is granted afterwards.
- m_rvalid pulsed in IDLE with data 0x1234 -> r0_rvalid = r1_rvalid = 0; state and counters unchanged.
- r0 load accepted, then rst_n pulsed low before m_rvalid, then m_rvalid arrives -> no rvalid on either requester; counters read 0; the next r1 request is granted normally.
